// File: rtl/gray_run_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : gray_run_arbiter
//  Purpose  : Two-requester round-robin arbiter and run sequencer for the
//             shared 3-bit gray counter. The granted requester's run length
//             is latched, the counter is cleared for one cycle, then enabled
//             for exactly that many cycles, after which a one-cycle done pulse
//             is issued to the owner. Counter overflows seen while running
//             are tallied in wrap_cnt.
//  Ports    : clk          - rising-edge clock
//             rst_n        - asynchronous active-low reset
//             req0/req1    - run requests
//             len0/len1    - run step counts, sampled only at grant
//             gnt0/gnt1    - owner of the counter (CLEAR, RUN, DONE)
//             done0/done1  - one-cycle run-complete pulse
//             busy         - sequencer is not idle
//             cnt_en       - gray counter enable
//             cnt_clr      - gray counter synchronous clear
//             cnt_value    - gray counter value (monitored only)
//             cnt_overflow - gray counter overflow flag
//             wrap_cnt     - overflows seen in the current or last run
//  Options  : GRAY_ARB_WRAP_CNT_EN - build the wrap tally; when undefined
//             wrap_cnt is tied to zero and cnt_overflow is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module gray_run_arbiter #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic             cnt_en,
    output logic             cnt_clr,
    input  logic [2:0]       cnt_value,
    input  logic             cnt_overflow,
    output logic [LEN_W-1:0] wrap_cnt
);

    localparam logic [LEN_W-1:0] c_ONE = LEN_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_owner;      // 0: requester 0 owns the counter
    logic             r_last;       // last requester granted
    logic [LEN_W-1:0] r_remaining;

    logic w_any_req;
    logic w_win;
    logic w_grant;
    logic w_owner_req;

    assign w_any_req   = req0 | req1;
    // On a tie the requester not granted last wins; otherwise the sole requester.
    assign w_win       = (req0 && req1) ? ~r_last : req1;
    assign w_grant     = (r_state == S_IDLE) && w_any_req;
    assign w_owner_req = r_owner ? req1 : req0;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // A zero-length run skips RUN entirely.
                w_state_nxt = (r_remaining == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                // Abort wins over completion: a dropped request never gets done.
                if (!w_owner_req) begin
                    w_state_nxt = S_IDLE;
                end else if (r_remaining == c_ONE) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Owner, round-robin pointer and remaining step count
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_remaining <= '0;
        end else if (w_grant) begin
            r_owner     <= w_win;
            r_last      <= w_win;
            r_remaining <= w_win ? len1 : len0;
        end else if (r_state == S_RUN) begin
            r_remaining <= r_remaining - c_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs, decoded from state and owner only
    // ------------------------------------------------------------------
    assign busy    = (r_state != S_IDLE);
    assign gnt0    = busy && !r_owner;
    assign gnt1    = busy &&  r_owner;
    assign cnt_clr = (r_state == S_CLEAR);
    assign cnt_en  = (r_state == S_RUN);
    assign done0   = (r_state == S_DONE) && !r_owner;
    assign done1   = (r_state == S_DONE) &&  r_owner;

    // ------------------------------------------------------------------
    // Overflow tally
    // ------------------------------------------------------------------
`ifdef GRAY_ARB_WRAP_CNT_EN
    localparam logic [LEN_W-1:0] c_WRAP_MAX = '1;

    logic [LEN_W-1:0] r_wrap_cnt;
    logic             w_unused;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrap_cnt <= '0;
        end else if (w_grant) begin
            r_wrap_cnt <= '0;
        end else if ((r_state == S_RUN) && cnt_overflow && (r_wrap_cnt != c_WRAP_MAX)) begin
            r_wrap_cnt <= r_wrap_cnt + c_ONE;
        end
    end

    assign wrap_cnt = r_wrap_cnt;
    assign w_unused = ^cnt_value;
`else
    logic w_unused;

    assign wrap_cnt = '0;
    assign w_unused = ^{cnt_value, cnt_overflow};
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_run_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gray_run_arbiter
//  Purpose  : Self-checking bench for gray_run_arbiter. A run-offset model
//             (cycles elapsed since grant) predicts every output each cycle;
//             directed scenarios add literal expectations on top.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gray_run_arbiter;

    localparam int LEN_W = 8;
    localparam int WRAP_MAX = (1 << LEN_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             req0, req1;
    logic [LEN_W-1:0] len0, len1;
    logic             gnt0, gnt1, done0, done1, busy, cnt_en, cnt_clr;
    logic [2:0]       cnt_value;
    logic             cnt_overflow;
    logic [LEN_W-1:0] wrap_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    gray_run_arbiter #(.LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0         (req0),
        .req1         (req1),
        .len0         (len0),
        .len1         (len1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .done0        (done0),
        .done1        (done1),
        .busy         (busy),
        .cnt_en       (cnt_en),
        .cnt_clr      (cnt_clr),
        .cnt_value    (cnt_value),
        .cnt_overflow (cnt_overflow),
        .wrap_cnt     (wrap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: a run is described by its owner, its length and
    // how many cycles have passed since the grant (offset 1 = clear,
    // 2..len+1 = enabled steps, len+2 = done).
    // ------------------------------------------------------------------
    bit m_busy;
    bit m_owner;
    bit m_last;
    int m_off;
    int m_len;
    int m_wrap;

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_last  = 1;
        m_off   = 0;
        m_len   = 0;
        m_wrap  = 0;
    endtask

    function automatic logic [6:0] model_outputs();
        logic en, clr, dn;
        clr = m_busy && (m_off == 1);
        en  = m_busy && (m_off >= 2) && (m_off <= m_len + 1);
        dn  = m_busy && (m_off == m_len + 2);
        return {m_busy && !m_owner, m_busy && m_owner,
                dn && !m_owner, dn && m_owner, m_busy, en, clr};
    endfunction

    // Advance the model across the next rising edge using the inputs now applied.
    task automatic model_step();
        logic [6:0] e;
        bit win;
        e = model_outputs();
        if (!m_busy) begin
            if (req0 || req1) begin
                win     = (req0 && req1) ? !m_last : req1;
                m_busy  = 1;
                m_owner = win;
                m_last  = win;
                m_len   = win ? int'(len1) : int'(len0);
                m_off   = 1;
                m_wrap  = 0;
            end
        end else if (e[1]) begin
`ifdef GRAY_ARB_WRAP_CNT_EN
            if (cnt_overflow && m_wrap < WRAP_MAX) m_wrap++;
`endif
            if (!(m_owner ? req1 : req0)) m_busy = 0;
            else m_off++;
        end else if (e[4] || e[3]) begin
            m_busy = 0;
        end else begin
            m_off++;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("outputs{g0,g1,d0,d1,busy,en,clr}",
            32'({gnt0, gnt1, done0, done1, busy, cnt_en, cnt_clr}), 32'(model_outputs()));
        chk("wrap_cnt", 32'(wrap_cnt), 32'(m_wrap));
    endtask

    // Apply inputs, let one rising edge pass, check at the falling edge.
    task automatic tick(input logic r0, input logic r1, input logic [7:0] l0,
                        input logic [7:0] l1, input logic ov);
        req0 = r0; req1 = r1; len0 = l0; len1 = l1; cnt_overflow = ov;
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0);
    endtask

    initial begin
        int n_en;
        logic r0, r1;
        rst_n = 0; req0 = 0; req1 = 0; len0 = 0; len1 = 0;
        cnt_overflow = 0; cnt_value = 3'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'({gnt0, gnt1, done0, done1, busy, cnt_en, cnt_clr}), 32'd0);
        chk("reset_wrap", 32'(wrap_cnt), 32'd0);
        rst_n = 1;

        // Tie and fairness, L=3: c1 CLEAR, c2-4 RUN, c5 DONE, c6 IDLE.
        tick(1, 1, 3, 3, 0);
        chk("tie_first_gnt0", 32'(gnt0), 32'd1);
        chk("tie_first_gnt1", 32'(gnt1), 32'd0);
        for (int k = 2; k <= 5; k++) tick(1, 1, 3, 3, 0);
        chk("tie_done0", 32'(done0), 32'd1);
        tick(0, 1, 3, 3, 0);
        chk("tie_idle_gap", 32'({gnt0, gnt1}), 32'd0);
        tick(0, 1, 3, 3, 0);
        chk("tie_second_gnt1", 32'({gnt0, gnt1}), 32'b01);
        for (int k = 8; k <= 11; k++) tick(0, 1, 3, 3, 0);
        chk("tie_done1", 32'(done1), 32'd1);
        tick(1, 1, 3, 3, 0);
        tick(1, 1, 3, 3, 0);
        chk("tie_third_gnt0", 32'({gnt0, gnt1}), 32'b10);
        for (int k = 14; k <= 17; k++) tick(1, 1, 3, 3, 0);
        chk("tie_third_done0", 32'(done0), 32'd1);
        drain();

        // Single run, L=5: en at c2..c6, done at c7, gnt low at c8.
        tick(1, 0, 5, 0, 0);
        chk("single_clr", 32'({gnt0, cnt_clr}), 32'b11);
        n_en = 0;
        for (int k = 2; k <= 7; k++) begin
            tick(1, 0, 5, 0, 0);
            if (cnt_en) n_en++;
        end
        chk("single_en_cycles", 32'(n_en), 32'd5);
        chk("single_done0", 32'(done0), 32'd1);
        tick(0, 0, 0, 0, 0);
        chk("single_gnt_low", 32'(gnt0), 32'd0);
        drain();

        // Zero length on requester 1.
        tick(0, 1, 0, 0, 0);
        chk("zero_clr", 32'({gnt1, cnt_clr}), 32'b11);
        tick(0, 1, 0, 0, 0);
        chk("zero_done1_no_en", 32'({done1, cnt_en}), 32'b10);
        tick(0, 0, 0, 0, 0);
        chk("zero_idle", 32'(busy), 32'd0);
        drain();

        // Abort: req0 dropped in third RUN cycle.
        tick(1, 0, 10, 0, 0);
        n_en = 0;
        for (int k = 2; k <= 4; k++) begin
            tick(1, 0, 10, 0, 0);
            if (cnt_en) n_en++;
        end
        tick(0, 0, 10, 0, 0);
        chk("abort_en_cycles", 32'(n_en), 32'd3);
        chk("abort_busy_done", 32'({busy, done0}), 32'd0);
        drain();

        // Wrap tally: overflow once in IDLE, then in RUN cycles 8 and 16.
        tick(0, 0, 0, 0, 1);
        tick(1, 0, 20, 0, 0);
        for (int k = 2; k <= 22; k++) tick(1, 0, 20, 0, (k == 10 || k == 18));
        chk("wrap_done0", 32'(done0), 32'd1);
`ifdef GRAY_ARB_WRAP_CNT_EN
        chk("wrap_count", 32'(wrap_cnt), 32'd2);
        tick(0, 0, 0, 0, 1);
        chk("wrap_hold", 32'(wrap_cnt), 32'd2);
`else
        chk("wrap_count_off", 32'(wrap_cnt), 32'd0);
        tick(0, 0, 0, 0, 1);
        chk("wrap_hold_off", 32'(wrap_cnt), 32'd0);
`endif
        drain();

        // Randomised traffic with occasional aborts.
        for (int i = 0; i < 600; i++) begin
            r0 = req0;
            r1 = req1;
            if (r0) begin
                if (done0 || $urandom_range(0, 39) == 0) r0 = 1'($urandom_range(0, 1));
            end else begin
                r0 = ($urandom_range(0, 3) == 0);
            end
            if (r1) begin
                if (done1 || $urandom_range(0, 39) == 0) r1 = 1'($urandom_range(0, 1));
            end else begin
                r1 = ($urandom_range(0, 3) == 0);
            end
            tick(r0, r1, 8'($urandom_range(0, 6)), 8'($urandom_range(0, 6)),
                 ($urandom_range(0, 3) == 0));
        end
        drain();

        // Asynchronous reset in the middle of a run.
        for (int k = 1; k <= 4; k++) tick(1, 0, 9, 0, 1);
        chk("pre_reset_running", 32'(cnt_en), 32'd1);
        #2;
        rst_n = 0;
        #1;
        chk("async_reset_outputs", 32'({gnt0, gnt1, done0, done1, busy, cnt_en, cnt_clr}), 32'd0);
        chk("async_reset_wrap", 32'(wrap_cnt), 32'd0);
        req0 = 0;
        cnt_overflow = 0;
        model_reset();
        @(negedge clk);
        compare_all();
        rst_n = 1;
        tick(1, 1, 2, 2, 0);
        chk("post_reset_tie_gnt0", 32'({gnt0, gnt1}), 32'b10);
        for (int k = 2; k <= 4; k++) tick(1, 1, 2, 2, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/gray_run_arbiter.md
# gray_run_arbiter

Two-requester round-robin arbiter and run sequencer for the shared 3-bit gray counter. Each requester asks for a run of a programmed number of count steps. The arbiter grants the counter to one requester and clears it. It then drives the counter enable for exactly that many cycles, tallies counter overflows, and pulses a per-requester done. The block sits between the requesting logic and the gray counter, and it is the only driver of the counter's enable and clear.

## Interface
Parameters:
- LEN_W, 8, width of run-length inputs and of the wrap tally

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Req0  in  1  run request from requester 0
- Req1  in  1  run request from requester 1
- Len0  in  LEN_W  step count for requester 0; sampled at grant
- Len1  in  LEN_W  step count for requester 1; sampled at grant
- Gnt0  out  1  requester 0 owns the counter
- Gnt1  out  1  requester 1 owns the counter
- Done0  out  1  one-cycle pulse: run for requester 0 completed
- Done1  out  1  one-cycle pulse: run for requester 1 completed
- Busy  out  1  state is not IDLE
- Cnt_En  out  1  enable to gray counter
- Cnt_Clr  out  1  synchronous clear to gray counter
- Cnt_Value  in  3  gray counter output; monitored only
- Cnt_Overflow  in  1  gray counter overflow flag
- Wrap_Cnt  out  LEN_W  overflows seen during the current or last run

## Operation
- FSM states: IDLE, CLEAR, RUN, DONE. All outputs are registered or Moore-decoded from state. No combinational path from Req to outputs.
- IDLE:
  - If any Req is high, select the owner. Latch the owner's Len into Remaining, clear Wrap_Cnt, and go to CLEAR.
  - If no Req is high, stay in IDLE.
- Arbitration:
  - Only one Req high: that requester wins.
  - Both high: the requester not granted last wins.
  - The Last pointer resets to 1, so Req0 wins the first tie.
  - Last updates at each grant.
- CLEAR: Cnt_Clr=1 for one cycle.
  - Next state is RUN if Remaining≠0.
  - Next state is DONE if Remaining==0, so a zero-length run issues no enable cycles.
- RUN:
  - Cnt_En=1 and Remaining decrements every cycle.
  - The cycle with Remaining==1 is the last enabled cycle; next state is DONE.
  - If the owner's Req is low during a RUN cycle, the run aborts: that cycle's enable still counts, next state is IDLE, and no Done pulse is issued.
- DONE: the owner's Done=1 for one cycle, Gnt stays high, and next state is IDLE.
- Gnt:
  - The owner's Gnt is high in CLEAR, RUN and DONE; low in IDLE.
  - Gnt0 and Gnt1 are never both high.
- Requester rule: hold Req high until Done. A Req still high in the first IDLE cycle after DONE is treated as a new request.
- Wrap tally: in RUN, each cycle with Cnt_En=1 and Cnt_Overflow=1 increments Wrap_Cnt. Wrap_Cnt saturates at 2^LEN_W−1 and holds its value after the run ends.
- Len inputs are ignored outside the grant cycle.

## Timing
- Reset low (asynchronous): state=IDLE, Gnt0=Gnt1=0, Done0=Done1=0, Busy=0, Cnt_En=0, Cnt_Clr=0, Wrap_Cnt=0, Remaining=0, Last=1.
- Run of length L≥1 with Req sampled high in IDLE at cycle 0:
  - cycle 1: CLEAR, Gnt and Cnt_Clr high.
  - cycles 2..L+1: RUN, Cnt_En high for exactly L cycles.
  - cycle L+2: DONE pulse.
  - cycle L+3: IDLE, Gnt low.
- L=0: CLEAR at cycle 1, DONE at cycle 2, IDLE at cycle 3.
- Minimum request-to-request turnaround is one IDLE cycle.
- Reset asserted mid-run: all outputs go to reset values immediately, with no Done pulse.

## Configuration
- GRAY_ARB_WRAP_CNT_EN defined: the Wrap_Cnt register and tally logic are built as described above.
- GRAY_ARB_WRAP_CNT_EN undefined: Wrap_Cnt is tied to 0, Cnt_Overflow is ignored, and all other behaviour is identical.

## Test plan
- Single run: Req0=1, Len0=5 from reset → Gnt0 and Cnt_Clr high at cycle 1; Cnt_En high at cycles 2–6; Done0 at cycle 7; Gnt0 low at cycle 8.
- Tie and fairness: Req0=Req1=1 held, Len0=Len1=3, each requester dropping Req after its Done → Gnt0 first; after Done0 and one IDLE cycle, Gnt1. With both re-raised, the next grant is Req0. Gnt0 and Gnt1 are never both high.
- Zero length: Req1=1, Len1=0 → Cnt_Clr for one cycle, no Cnt_En, Done1 at cycle 2.
- Abort: Req0=1, Len0=10, Req0 dropped in the 3rd RUN cycle → exactly 3 Cnt_En cycles, no Done0, Busy low on the following cycle.
- Wrap tally (macro defined): Len0=20, bench pulses Cnt_Overflow in RUN cycles 8 and 16 plus one cycle while in IDLE → Wrap_Cnt=2 after Done0. With the macro undefined, Wrap_Cnt stays 0.
- Async reset: Reset low mid-RUN, asynchronous to Clk → all outputs 0 without waiting for a clock edge. After release, a tie grants Req0.
